iob2axi_rd_split: RTL and testbench

IOB2AXI_RD_SPLIT -- requirements
Module: iob2axi_rd_split

---
 rtl/iob2axi_rd_split.sv | 148 ++++++++++++++
 tb/tb_iob2axi_rd_split.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob2axi_rd_split.sv
// Splits a long read of nwords beats into AXI-sized bursts that never exceed
// MAX_BURST beats and never cross a 4 KB page, handing each to a read engine.
module iob2axi_rd_split #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_LEN_W = 8,
    parameter int MAX_BURST = 256,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    base_addr_i,
    input  logic [CNT_W-1:0]     nwords_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic                 run_o,
    output logic [ADDR_W-1:0]    addr_o,
    output logic [AXI_LEN_W-1:0] length_o,
    input  logic                 rd_ready_i,
    input  logic                 rd_error_i
);

    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = $clog2(BYTES);
    // Common width wide enough for the remaining count, the 13-bit page term and MAX_BURST.
    localparam int MW0 = (CNT_W > 13) ? CNT_W : 13;
    localparam int MW  = (MW0 > AXI_LEN_W + 1) ? MW0 : AXI_LEN_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE,
        WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]       remaining_q, remaining_d;
    logic [AXI_LEN_W:0]     beats_q, beats_d;
    logic [AXI_LEN_W-1:0]   length_q, length_d;
    logic                   error_q, error_d;
    logic                   done_q, done_d;

    logic [ADDR_W-1:0]      aligned_base;
    logic [12:0]            page_off;
    logic [12:0]            page_bytes;
    logic [12:0]            page_beats;
    logic [MW-1:0]          beats_w;
    logic [ADDR_W-1:0]      addr_step;
    logic [CNT_W-1:0]       rem_next;

    assign aligned_base = base_addr_i & ~ADDR_W'(BYTES - 1);
    assign page_off     = {1'b0, cur_addr_q[11:0]};
    assign page_bytes   = 13'd4096 - page_off;
    assign page_beats   = page_bytes >> BSH;
    assign addr_step    = ADDR_W'(beats_q) << BSH;
    assign rem_next     = remaining_q - CNT_W'(beats_q);

    // Burst size is the smallest of what is left, the burst cap and the room to the page end.
    always_comb begin
        beats_w = MW'(remaining_q);
        if (MW'(MAX_BURST) < beats_w) begin
            beats_w = MW'(MAX_BURST);
        end
        if (MW'(page_beats) < beats_w) begin
            beats_w = MW'(page_beats);
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        beats_d     = beats_q;
        length_d    = length_q;
        error_d     = error_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cur_addr_d  = aligned_base;
                    remaining_d = nwords_i;
                    error_d     = 1'b0;
                    if (nwords_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                beats_d  = beats_w[AXI_LEN_W:0];
                length_d = AXI_LEN_W'(beats_w - 1'b1);
                state_d  = ISSUE;
            end
            ISSUE: begin
                if (!rd_ready_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (rd_ready_i) begin
                    error_d     = error_q | rd_error_i;
                    cur_addr_d  = cur_addr_q + addr_step;
                    remaining_d = rem_next;
                    // A failed burst ends the transfer even if beats remain.
                    if ((rem_next == '0) || rd_error_i) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            beats_q     <= '0;
            length_q    <= '0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            beats_q     <= beats_d;
            length_q    <= length_d;
            error_q     <= error_d;
            done_q      <= done_d;
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign run_o    = (state_q == ISSUE);
    assign addr_o   = cur_addr_q;
    assign length_o = length_q;
    assign done_o   = done_q;
    assign error_o  = error_q;

endmodule

// File: tb/tb_iob2axi_rd_split.sv
// Randomized bench for iob2axi_rd_split: a simple read-engine responder plus a
// burst-list model computed from page/burst-size arithmetic.
module tb_iob2axi_rd_split;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int AXI_LEN_W = 8;
    localparam int MAX_BURST = 256;
    localparam int CNT_W     = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] baseAddr = '0;
    logic [15:0] nWords = '0;
    logic        busy, done, err, run;
    logic [31:0] addrO;
    logic [7:0]  lenO;
    logic        rdReady = 1'b1;
    logic        rdError = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } burst_t;

    burst_t expQ[$];
    burst_t obsQ[$];

    int checks = 0;
    int failures = 0;
    int doneCount = 0;
    int runCount = 0;
    int busyCycles = 0;
    int engDelay = -1;
    int errBurst = -1;
    int engBurstIdx = 0;

    iob2axi_rd_split #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AXI_LEN_W(AXI_LEN_W),
        .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(baseAddr),
        .nwords_i(nWords), .busy_o(busy), .done_o(done), .error_o(err),
        .run_o(run), .addr_o(addrO), .length_o(lenO),
        .rd_ready_i(rdReady), .rd_error_i(rdError)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected burst list: walk the transfer, cutting at 256 beats and at every 4 KB page.
    function automatic int buildModel(input logic [31:0] base, input int nw);
        logic [31:0] a;
        int rem, page, b;
        burst_t bt;
        expQ.delete();
        a = base & 32'hFFFF_FFFC;
        rem = nw;
        while (rem > 0) begin
            page = (4096 - int'(a % 32'd4096)) / 4;
            b = rem;
            if (b > MAX_BURST) b = MAX_BURST;
            if (page < b) b = page;
            bt.addr = a;
            bt.len = 8'(b - 1);
            expQ.push_back(bt);
            a = a + 32'(b * 4);
            rem -= b;
        end
        return expQ.size();
    endfunction

    // Read engine: accepts the address after a delay, then stays busy a few cycles.
    initial begin
        int ePhase, eCnt;
        logic curErr;
        ePhase = 0;
        eCnt = 0;
        curErr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ePhase = 0;
                rdReady = 1'b1;
                rdError = 1'b0;
            end else begin
                case (ePhase)
                    0: begin
                        rdError = 1'b0;
                        if (run) begin
                            curErr = (engBurstIdx == errBurst);
                            engBurstIdx++;
                            eCnt = (engDelay >= 0) ? engDelay : int'($urandom_range(0, 3));
                            if (eCnt == 0) begin
                                rdReady = 1'b0;
                                eCnt = int'($urandom_range(1, 4));
                                ePhase = 2;
                            end else begin
                                ePhase = 1;
                            end
                        end
                    end
                    1: begin
                        eCnt--;
                        if (eCnt == 0) begin
                            rdReady = 1'b0;
                            eCnt = int'($urandom_range(1, 4));
                            ePhase = 2;
                        end
                    end
                    default: begin
                        eCnt--;
                        if (eCnt == 0) begin
                            rdReady = 1'b1;
                            rdError = curErr;
                            ePhase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Compare process: every burst against the model, and holding while run is high.
    initial begin
        logic prevRun, prevDone;
        burst_t cur, e;
        prevRun = 1'b0;
        prevDone = 1'b0;
        cur.addr = '0;
        cur.len = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevRun = 1'b0;
                prevDone = 1'b0;
            end else begin
                if (done) begin
                    doneCount++;
                    checkOutput("busy_low_on_done", 64'(busy), 64'(0));
                    checkOutput("done_single_cycle", 64'(prevDone), 64'(0));
                end
                if (busy) busyCycles++;
                if (run) begin
                    checkOutput("busy_during_run", 64'(busy), 64'(1));
                    if (!prevRun) begin
                        runCount++;
                        cur.addr = addrO;
                        cur.len = lenO;
                        obsQ.push_back(cur);
                        if (expQ.size() == 0) begin
                            checkOutput("burst_expected", 64'(expQ.size()), 64'(1));
                        end else begin
                            e = expQ.pop_front();
                            checkOutput("burst_addr", 64'(addrO), 64'(e.addr));
                            checkOutput("burst_len", 64'(lenO), 64'(e.len));
                        end
                    end else begin
                        checkOutput("hold_addr", 64'(addrO), 64'(cur.addr));
                        checkOutput("hold_len", 64'(lenO), 64'(cur.len));
                    end
                end
                prevRun = run;
                prevDone = done;
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] base, input int nw, input int errB,
                                 input int delay, input bit glitch);
        int nb, expBursts, d0, r0, b0, cyc;
        logic expErr;
        bit finished;
        nb = buildModel(base, nw);
        expErr = (errB >= 0) && (errB < nb);
        expBursts = expErr ? errB + 1 : nb;
        errBurst = errB;
        engDelay = delay;
        engBurstIdx = 0;
        obsQ.delete();
        d0 = doneCount;
        r0 = runCount;
        b0 = busyCycles;
        @(negedge clk);
        start = 1'b1;
        baseAddr = base;
        nWords = 16'(nw);
        @(negedge clk);
        start = 1'b0;
        if (nw == 0) begin
            checkOutput("zero_done_next_cycle", 64'(done), 64'(1));
        end else begin
            checkOutput("busy_after_start", 64'(busy), 64'(1));
            checkOutput("error_cleared", 64'(err), 64'(0));
        end
        finished = 1'b0;
        cyc = 0;
        while (!finished && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (glitch && cyc == 2) begin
                start = 1'b1;
                baseAddr = 32'h0000_5550;
                nWords = 16'd3;
            end else if (glitch && cyc == 3) begin
                start = 1'b0;
            end
            finished = (doneCount != d0);
        end
        if (!finished) checkOutput("done_timeout", 64'(doneCount - d0), 64'(1));
        repeat (3) @(negedge clk);
        checkOutput("done_count", 64'(doneCount - d0), 64'(1));
        checkOutput("error_flag", 64'(err), 64'(expErr));
        checkOutput("burst_count", 64'(runCount - r0), 64'(expBursts));
        checkOutput("busy_idle", 64'(busy), 64'(0));
        if (nw == 0) checkOutput("zero_no_busy", 64'(busyCycles - b0), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int nb, d0, cyc;
        logic [31:0] rb;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_error", 64'(err), 64'(0));
        checkOutput("reset_run", 64'(run), 64'(0));
        checkOutput("reset_addr", 64'(addrO), 64'(0));
        checkOutput("reset_len", 64'(lenO), 64'(0));
        rst = 1'b0;

        applyStimulus(32'h0000_0000, 300, -1, -1, 1'b0);
        checkOutput("r034_nbursts", 64'(obsQ.size()), 64'(2));
        if (obsQ.size() >= 2) begin
            checkOutput("r034_b0_addr", 64'(obsQ[0].addr), 64'h000);
            checkOutput("r034_b0_len", 64'(obsQ[0].len), 64'd255);
            checkOutput("r034_b1_addr", 64'(obsQ[1].addr), 64'h400);
            checkOutput("r034_b1_len", 64'(obsQ[1].len), 64'd43);
        end

        applyStimulus(32'h0000_0FF0, 8, -1, -1, 1'b0);
        checkOutput("r035_nbursts", 64'(obsQ.size()), 64'(2));
        if (obsQ.size() >= 2) begin
            checkOutput("r035_b0_addr", 64'(obsQ[0].addr), 64'hFF0);
            checkOutput("r035_b0_len", 64'(obsQ[0].len), 64'd3);
            checkOutput("r035_b1_addr", 64'(obsQ[1].addr), 64'h1000);
            checkOutput("r035_b1_len", 64'(obsQ[1].len), 64'd3);
        end

        applyStimulus(32'h0000_1234, 0, -1, -1, 1'b0);

        applyStimulus(32'h0000_0000, 512, 0, -1, 1'b0);
        checkOutput("r037_one_burst", 64'(obsQ.size()), 64'(1));

        applyStimulus(32'h0000_3000, 40, -1, 5, 1'b1);

        applyStimulus(32'hFFFF_FFF8, 4, -1, -1, 1'b0);
        if (obsQ.size() >= 2) begin
            checkOutput("wrap_b1_addr", 64'(obsQ[1].addr), 64'h0);
            checkOutput("wrap_b1_len", 64'(obsQ[1].len), 64'd1);
        end

        applyStimulus(32'h0000_0103, 2, -1, -1, 1'b0);
        if (obsQ.size() >= 1) checkOutput("misaligned_addr", 64'(obsQ[0].addr), 64'h100);

        // Reset while the engine holds the burst in flight.
        nb = buildModel(32'h0, 512);
        errBurst = -1;
        engDelay = 1;
        engBurstIdx = 0;
        @(negedge clk);
        start = 1'b1;
        baseAddr = 32'h0;
        nWords = 16'd512;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(busy && !run && !rdReady) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("reach_wait", 64'(busy && !run && !rdReady), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_run", 64'(run), 64'(0));
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_addr", 64'(addrO), 64'(0));
        checkOutput("rst_len", 64'(lenO), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        d0 = doneCount;
        repeat (10) @(negedge clk);
        checkOutput("no_done_after_reset", 64'(doneCount - d0), 64'(0));
        applyStimulus(32'h0000_2000, 20, -1, -1, 1'b0);

        for (int i = 0; i < 15; i++) begin
            rb = {$urandom} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1) rb[11:0] = 12'(4096 - 4 * int'($urandom_range(1, 8)));
            applyStimulus(rb, int'($urandom_range(1, 700)),
                          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                          -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
